// File: rtl/snax_task_csr_queue_pkg.sv
// CSR address map and FSM state type shared by the SNAX task CSR queue.
package csr_snax_def;

  localparam logic [11:0] CSR_SNAX_READ_TASK_READY_QUEUE = 12'h5fe;
  localparam logic [11:0] CSR_SNAX_WRITE_TASK_DONE_QUEUE = 12'h5ff;

  typedef enum logic {
    SNAX_TASK_Q_IDLE,
    SNAX_TASK_Q_RESP
  } snax_task_q_state_e;

endpackage

// File: rtl/snax_task_csr_queue_fifo.sv
// Valid/ready task FIFO with registered full/empty flags and wrap-bit pointers.
// SNAX_TASK_QUEUE_STATUS_EN adds a registered occupancy counter output.
module snax_task_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [Width-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [Width-1:0]       pop_data
`ifdef SNAX_TASK_QUEUE_STATUS_EN
  ,
  output logic [$clog2(Depth):0] count
`endif
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wptr, rptr, wptr_next, rptr_next;
  logic             full, empty;
  logic             do_push, do_pop;

  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = mem[rptr[AW-1:0]];

  assign do_push = push_valid && !full;
  assign do_pop  = pop_ready && !empty;

  assign wptr_next = wptr + PW'(do_push);
  assign rptr_next = rptr + PW'(do_pop);

  // Flags are derived from next pointers so they are valid straight from the flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      empty <= (wptr_next == rptr_next);
      full  <= (wptr_next[AW] != rptr_next[AW]) &&
               (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

`ifdef SNAX_TASK_QUEUE_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`endif

endmodule

// File: rtl/snax_task_csr_queue.sv
// CSR front end for SNAX task queues: 0x5fe read pops the ready queue, 0x5ff write pushes the done queue.
// SNAX_TASK_QUEUE_STATUS_EN makes a 0x5ff read return {done occupancy, ready occupancy}.
module snax_task_csr_queue
  import csr_snax_def::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned ReadyDepth = 4,
  parameter int unsigned DoneDepth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 csr_req_valid_i,
  output logic                 csr_req_ready_o,
  input  logic [11:0]          csr_req_addr_i,
  input  logic                 csr_req_write_i,
  input  logic [DataWidth-1:0] csr_req_data_i,
  output logic                 csr_rsp_valid_o,
  input  logic                 csr_rsp_ready_i,
  output logic [DataWidth-1:0] csr_rsp_data_o,
  input  logic                 task_in_valid_i,
  output logic                 task_in_ready_o,
  input  logic [DataWidth-1:0] task_in_data_i,
  output logic                 task_done_valid_o,
  input  logic                 task_done_ready_i,
  output logic [DataWidth-1:0] task_done_data_o
);

  snax_task_q_state_e state, state_next;

  logic                 ready_push_ready, ready_pop_valid, ready_pop;
  logic                 done_push_ready, done_pop_valid, done_push;
  logic [DataWidth-1:0] ready_head, done_head;
  logic [DataWidth-1:0] rsp_data, rsp_data_next;
  logic                 is_rd_ready, is_wr_done, is_rd_done;
  logic                 req_ready, accept;

  assign is_rd_ready = !csr_req_write_i && (csr_req_addr_i == CSR_SNAX_READ_TASK_READY_QUEUE);
  assign is_wr_done  =  csr_req_write_i && (csr_req_addr_i == CSR_SNAX_WRITE_TASK_DONE_QUEUE);
  assign is_rd_done  = !csr_req_write_i && (csr_req_addr_i == CSR_SNAX_WRITE_TASK_DONE_QUEUE);

  assign accept    = csr_req_valid_i && req_ready;
  assign ready_pop = accept && is_rd_ready;
  assign done_push = accept && is_wr_done;

`ifdef SNAX_TASK_QUEUE_STATUS_EN
  logic [$clog2(ReadyDepth):0] ready_count;
  logic [$clog2(DoneDepth):0]  done_count;
  logic [DataWidth-1:0]        status;
  assign status = DataWidth'({16'(done_count), 16'(ready_count)});
`endif

  snax_task_fifo #(
    .Width (DataWidth),
    .Depth (ReadyDepth)
  ) i_ready_q (
    .clk        (clk_i),
    .rst        (rst_i),
    .push_valid (task_in_valid_i),
    .push_ready (ready_push_ready),
    .push_data  (task_in_data_i),
    .pop_valid  (ready_pop_valid),
    .pop_ready  (ready_pop),
    .pop_data   (ready_head)
`ifdef SNAX_TASK_QUEUE_STATUS_EN
    ,
    .count      (ready_count)
`endif
  );

  snax_task_fifo #(
    .Width (DataWidth),
    .Depth (DoneDepth)
  ) i_done_q (
    .clk        (clk_i),
    .rst        (rst_i),
    .push_valid (done_push),
    .push_ready (done_push_ready),
    .push_data  (csr_req_data_i),
    .pop_valid  (done_pop_valid),
    .pop_ready  (task_done_ready_i),
    .pop_data   (done_head)
`ifdef SNAX_TASK_QUEUE_STATUS_EN
    ,
    .count      (done_count)
`endif
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SNAX_TASK_Q_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stalls use the registered queue flags, so a same-cycle push/pop never unblocks a request.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rsp_data_next = '0;
    unique case (state)
      SNAX_TASK_Q_IDLE: begin
        req_ready = !rst_i &&
                    !(is_rd_ready && !ready_pop_valid) &&
                    !(is_wr_done && !done_push_ready);
        if (csr_req_valid_i && req_ready) begin
          state_next = SNAX_TASK_Q_RESP;
        end
      end
      SNAX_TASK_Q_RESP: begin
        if (csr_rsp_ready_i) begin
          state_next = SNAX_TASK_Q_IDLE;
        end
      end
      default: state_next = SNAX_TASK_Q_IDLE;
    endcase
    if (is_rd_ready) begin
      rsp_data_next = ready_head;
    end else if (is_rd_done) begin
`ifdef SNAX_TASK_QUEUE_STATUS_EN
      rsp_data_next = status;
`else
      rsp_data_next = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_data <= '0;
    end else if (accept) begin
      rsp_data <= rsp_data_next;
    end
  end

  assign csr_req_ready_o   = req_ready;
  assign csr_rsp_valid_o   = (state == SNAX_TASK_Q_RESP) && !rst_i;
  assign csr_rsp_data_o    = rst_i ? '0 : rsp_data;
  assign task_in_ready_o   = ready_push_ready && !rst_i;
  assign task_done_valid_o = done_pop_valid && !rst_i;
  assign task_done_data_o  = done_head;

endmodule

// File: doc/snax_task_csr_queue.md
SNAX_TASK_CSR_QUEUE -- requirements
Module: snax_task_csr_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of task descriptors and CSR data.
REQ-002 SHALL have parameter ReadyDepth, default 4: ready-queue entries, power of two, at least 2.
REQ-003 SHALL have parameter DoneDepth, default 4: done-queue entries, power of two, at least 2.
REQ-004 SHALL have clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have csr_req_valid_i / csr_req_ready_o, in/out, 1 each: CSR request handshake from the core.
REQ-007 SHALL have csr_req_addr_i, input, 12: CSR address, already decoded to the SNAX range 0x3c0–0x5ff.
REQ-008 SHALL have csr_req_write_i, input, 1 (1 = write), and csr_req_data_i, input, DataWidth: write data.
REQ-009 SHALL have csr_rsp_valid_o / csr_rsp_ready_i, out/in, 1 each, and csr_rsp_data_o, output, DataWidth: the response channel.
REQ-010 SHALL have task_in_valid_i / task_in_ready_o / task_in_data_i, in/out/in, 1/1/DataWidth: upstream task push into the ready queue.
REQ-011 SHALL have task_done_valid_o / task_done_ready_i / task_done_data_o, out/in/out, 1/1/DataWidth: downstream done-task pop.

Function
REQ-012 SHALL decode 0x5fe (CSR_SNAX_READ_TASK_READY_QUEUE) as follows: a read pops the ready queue head and returns it.
REQ-013 SHALL decode 0x5ff (CSR_SNAX_WRITE_TASK_DONE_QUEUE) as follows: a write pushes csr_req_data_i into the done queue.
REQ-014 SHALL accept any other address in one cycle; writes to it have no effect and reads return 0.
REQ-015 SHALL accept a write to 0x5fe in one cycle with no effect.
REQ-016 SHALL use a two-state FSM: IDLE accepts requests; RESP holds a response.
REQ-017 FSM transitions SHALL be: IDLE→RESP on acceptance; RESP→IDLE on csr_rsp_ready_i.
REQ-018 SHALL drive csr_req_ready_o low in RESP, so at most one request is outstanding.
REQ-019 SHALL produce exactly one response per accepted request, registered, with csr_rsp_valid_o high the cycle after acceptance.
REQ-020 Write responses SHALL carry data 0.
REQ-021 SHALL hold csr_rsp_data_o stable while csr_rsp_valid_o is high and csr_rsp_ready_i is low.
REQ-022 In IDLE, a read of 0x5fe while the ready queue is empty SHALL keep csr_req_ready_o low (stall) until the queue is non-empty.
REQ-023 In IDLE, a write of 0x5ff while the done queue is full SHALL keep csr_req_ready_o low until space frees.
REQ-024 Empty and full SHALL be registered flags: a same-cycle push into an empty ready queue does not satisfy a stalled pop; a same-cycle downstream pop of a full done queue does not admit a stalled write. Acceptance occurs on the next cycle.
REQ-025 SHALL drive task_in_ready_o = !ready_full and task_done_valid_o = !done_empty, with task_done_data_o = done-queue head.
REQ-026 Pointers SHALL wrap modulo depth, using an extra wrap bit to distinguish full from empty.
REQ-027 Simultaneous push and pop on one queue SHALL leave occupancy unchanged and preserve FIFO order.

Reset
REQ-028 While rst_i is high: both queues SHALL be flushed and the FSM SHALL be in IDLE.
REQ-029 While rst_i is high: csr_req_ready_o, csr_rsp_valid_o, task_in_ready_o and task_done_valid_o SHALL be 0, and csr_rsp_data_o SHALL be 0.
REQ-030 Reset asserted while in RESP SHALL drop the pending response, which is never presented afterwards.
REQ-031 The first cycle after rst_i deasserts SHALL have task_in_ready_o=1 and csr_req_ready_o=1 unless blocked by REQ-022 or REQ-023.

Configuration
REQ-032 With SNAX_TASK_QUEUE_STATUS_EN defined, a read of 0x5ff SHALL return {done occupancy in [31:16], ready occupancy in [15:0]}, zero-extended, with no pop.
REQ-033 Without SNAX_TASK_QUEUE_STATUS_EN, a read of 0x5ff SHALL return 0 and the occupancy counters SHALL not be built.

Structure
REQ-034 The address constants SHALL come from package csr_snax_def.
REQ-035 The FSM state enum snax_task_q_state_e SHALL be added to csr_snax_def.
REQ-036 Each queue SHALL be an instance of one sub-module snax_task_fifo (parameters Width, Depth; push/pop valid-ready; registered full/empty/count), instantiated twice.

Verification
REQ-037 Bench SHALL: push tasks 0xA1, 0xA2 via task_in; two CSR reads of 0x5fe -> responses 0xA1 then 0xA2, each one cycle after acceptance.
REQ-038 Bench SHALL: CSR read 0x5fe on empty queue; push 0x55 at cycle 5 -> request accepted at cycle 6, response 0x55 at cycle 7.
REQ-039 Bench SHALL: hold task_done_ready_i=0 and issue 5 writes of 0x5ff (data 1..5), DoneDepth=4 -> 4 accepted, 5th stalls; release -> done outputs 1,2,3,4,5 in order.
REQ-040 Bench SHALL: hold csr_rsp_ready_i=0 for 3 cycles after a read -> csr_rsp_data_o stable and csr_req_ready_o=0 throughout.
REQ-041 Bench SHALL: assert rst_i while in RESP with 3 tasks queued -> next cycle rsp_valid=0, ready queue empty, and a subsequent read stalls.
REQ-042 Bench SHALL, with SNAX_TASK_QUEUE_STATUS_EN: 2 ready tasks, 1 done entry; read 0x5ff -> 0x0001_0002, occupancies unchanged.
